// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and FIFO entry type for the instruction-fetch sequencer.
package fetch_pkg;

   localparam logic [31:0] HALT_WORD = 32'h0000_0063;
   localparam int unsigned ENTRY_W   = 64;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   // Only the last legal word wraps; addresses past the end simply keep counting.
   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc, input logic [31:0] last_pc);
      if (pc == last_pc) begin
         next_seq_pc = 32'h0000_0000;
      end else begin
         next_seq_pc = pc + 32'd4;
      end
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake, redirect input and halt status.
interface fetch_sequencer_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_word;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;

   modport master (
      output imem_addr, inst_valid, inst_word, inst_pc, halted,
      input  imem_data, inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, inst_valid, inst_word, inst_pc, halted,
      output imem_data, inst_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Shift-register prefetch FIFO: entry 0 is always the head, so the head output comes straight from a flop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] ent_q [DEPTH];
   logic [WIDTH-1:0] ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic             pop_s;
   logic             push_s;
   logic             taken_s;

   // Next-state: flush, else shift on pop, then drop the push into the first free slot.
   always_comb begin
      pop_s   = pop && vld_q[0];
      push_s  = push && (!vld_q[DEPTH-1] || pop_s);
      ent_d   = ent_q;
      vld_d   = vld_q;
      taken_s = !push_s;
      if (flush) begin
         vld_d = {DEPTH{1'b0}};
      end else begin
         if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               ent_d[i] = ent_q[i+1];
               vld_d[i] = vld_q[i+1];
            end
            vld_d[DEPTH-1] = 1'b0;
         end else begin
            vld_d = vld_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (!taken_s && !vld_d[i]) begin
               ent_d[i] = push_data;
               vld_d[i] = 1'b1;
               taken_s  = 1'b1;
            end else begin
               taken_s = taken_s;
            end
         end
      end
   end

   // Storage and valid bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= {WIDTH{1'b0}};
         end
         vld_q <= {DEPTH{1'b0}};
      end else begin
         ent_q <= ent_d;
         vld_q <= vld_d;
      end
   end

   assign full  = vld_q[DEPTH-1];
   assign empty = !vld_q[0];
   assign head  = ent_q[0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, prefetches into fetch_fifo, handles redirects.
// Optional macro HALT_DETECT_EN stops fetching at the beq x0,x0,0 self-loop and reports halted.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned MEM_WORDS  = 21,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus
);

   localparam logic [31:0] LAST_PC = 32'(4 * (MEM_WORDS - 1));

   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   fetch_state_e state_q;
   fetch_state_e state_d;
   logic         fifo_full_s;
   logic         fifo_empty_s;
   logic         pop_s;
   logic         push_s;
   fetch_entry_t push_entry_s;
   fetch_entry_t head_s;

   // PC, FSM and push/pop decisions; a redirect discards this cycle's push and pop.
   always_comb begin
      pop_s             = !fifo_empty_s && bus.inst_ready && !bus.redirect_valid;
      push_entry_s.pc   = pc_q;
      push_entry_s.word = bus.imem_data;
      push_s            = 1'b0;
      pc_d              = pc_q;
      state_d           = state_q;
      if (bus.redirect_valid) begin
         pc_d    = {bus.redirect_pc[31:2], 2'b00};
         state_d = RUN;
      end else if ((state_q == RUN) && (!fifo_full_s || pop_s)) begin
         push_s = 1'b1;
`ifdef HALT_DETECT_EN
         if (bus.imem_data == HALT_WORD) begin
            state_d = HALT;
         end else begin
            pc_d = next_seq_pc(pc_q, LAST_PC);
         end
`else
         pc_d = next_seq_pc(pc_q, LAST_PC);
`endif
      end else begin
         push_s = 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .pop       (pop_s),
      .flush     (bus.redirect_valid),
      .push_data (push_entry_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .head      (head_s)
   );

`ifdef HALT_DETECT_EN
   logic halted_q;
   logic halted_d;

   // halted lags "HALT with an empty FIFO" by one cycle; any redirect clears it.
   always_comb begin
      if (bus.redirect_valid) begin
         halted_d = 1'b0;
      end else begin
         halted_d = (state_q == HALT) && fifo_empty_s;
      end
   end

   // Sequencer state with halt status.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         state_q  <= RUN;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   assign bus.halted = halted_q;
`else
   // Sequencer state.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   assign bus.halted = 1'b0;
`endif

   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = !fifo_empty_s;
   assign bus.inst_word  = head_s.word;
   assign bus.inst_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic vs. a queue model.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int unsigned MEM_WORDS  = 21;
   localparam int unsigned FIFO_DEPTH = 2;
`ifdef HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] mem [0:255];

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_PC   (RESET_PC),
      .MEM_WORDS  (MEM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_data = (bus.imem_addr[31:10] == 22'd0) ? mem[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (a[31:10] == 22'd0) return mem[a[9:2]];
      else return 32'hDEAD_BEEF;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
      step(); step();
      n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.inst_valid); end
      n_checks++; if (bus.inst_word !== 32'h0) begin n_fail++; $display("FAIL reset_word: got %h expected 0", bus.inst_word); end
      n_checks++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", bus.inst_pc); end
      n_checks++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", bus.imem_addr, RESET_PC); end
      n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b expected 0", bus.halted); end
   endtask

   task automatic test_cold_start();
      bus.inst_ready = 1'b1;
      reset = 1'b0;
      n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL cold_valid0: got %0b expected 0", bus.inst_valid); end
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL cold_valid k=%0d: got %0b expected 1", k, bus.inst_valid); end
         n_checks++; if (bus.inst_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL cold_pc k=%0d: got %h expected %h", k, bus.inst_pc, 4 * k); end
         n_checks++; if (bus.inst_word !== mem[k]) begin n_fail++; $display("FAIL cold_word k=%0d: got %h expected %h", k, bus.inst_word, mem[k]); end
         n_checks++; if (bus.imem_addr !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL cold_addr k=%0d: got %h expected %h", k, bus.imem_addr, 4 * k + 4); end
      end
   endtask

   task automatic test_backpressure();
      reset = 1'b1; bus.inst_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         n_checks++; if (bus.inst_pc !== 32'h0 || bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_pc k=%0d: got %h/%0b expected 0/1", k, bus.inst_pc, bus.inst_valid); end
         n_checks++; if (bus.inst_word !== mem[0]) begin n_fail++; $display("FAIL bp_hold_word k=%0d: got %h expected %h", k, bus.inst_word, mem[0]); end
         n_checks++; if (bus.imem_addr !== ((k == 1) ? 32'h4 : 32'h8)) begin n_fail++; $display("FAIL bp_addr k=%0d: got %h", k, bus.imem_addr); end
      end
      bus.inst_ready = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         n_checks++; if (bus.inst_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL bp_release_pc k=%0d: got %h expected %h", k, bus.inst_pc, 4 * k); end
         n_checks++; if (bus.imem_addr !== 32'(8 + 4 * k)) begin n_fail++; $display("FAIL bp_release_addr k=%0d: got %h expected %h", k, bus.imem_addr, 8 + 4 * k); end
      end
   endtask

   task automatic test_redirect();
      // FIFO now holds pc 8 and 12; hold decode off and redirect.
      bus.inst_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0031;
      step();
      bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1;
      n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %0b expected 0", bus.inst_valid); end
      n_checks++; if (bus.imem_addr !== 32'h30) begin n_fail++; $display("FAIL redir_addr: got %h expected 30", bus.imem_addr); end
      step();
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h30) begin n_fail++; $display("FAIL redir_target: got %0b/%h expected 1/30", bus.inst_valid, bus.inst_pc); end
      n_checks++; if (bus.inst_word !== mem[12]) begin n_fail++; $display("FAIL redir_word: got %h expected %h", bus.inst_word, mem[12]); end
   endtask

   task automatic test_wrap();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0050;
      step();
      bus.redirect_valid = 1'b0;
      n_checks++; if (bus.imem_addr !== 32'h50 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_redir: got %h/%0b expected 50/0", bus.imem_addr, bus.inst_valid); end
      step();
      n_checks++; if (bus.inst_pc !== 32'h50 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_last: got pc %h addr %h expected 50/0", bus.inst_pc, bus.imem_addr); end
      step();
      n_checks++; if (bus.inst_pc !== 32'h0 || bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL wrap_first: got pc %h addr %h expected 0/4", bus.inst_pc, bus.imem_addr); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0040;
      step();
      reset = 1'b0; bus.redirect_valid = 1'b0;
      n_checks++; if (bus.imem_addr !== RESET_PC || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got %h/%0b expected %h/0", bus.imem_addr, bus.inst_valid, RESET_PC); end
      step();
      n_checks++; if (bus.inst_pc !== RESET_PC || bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_first: got %h/%0b expected %h/1", bus.inst_pc, bus.inst_valid, RESET_PC); end
   endtask

`ifdef HALT_DETECT_EN
   task automatic test_halt();
      logic [31:0] saved;
      saved = mem[13]; mem[13] = HALT_WORD;
      reset = 1'b1; bus.inst_ready = 1'b1; bus.redirect_valid = 1'b0;
      step(); step();
      reset = 1'b0;
      for (int k = 0; k < 14; k++) begin
         step();
         n_checks++; if (bus.inst_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL halt_seq k=%0d: got %h expected %h", k, bus.inst_pc, 4 * k); end
      end
      n_checks++; if (bus.imem_addr !== 32'd52) begin n_fail++; $display("FAIL halt_addr_hold: got %h expected 34", bus.imem_addr); end
      step();
      n_checks++; if (bus.inst_valid !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_drain: got v%0b h%0b expected v0 h0", bus.inst_valid, bus.halted); end
      step();
      n_checks++; if (bus.halted !== 1'b1 || bus.imem_addr !== 32'd52) begin n_fail++; $display("FAIL halt_set: got h%0b addr %h expected h1 34", bus.halted, bus.imem_addr); end
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
      step();
      bus.redirect_valid = 1'b0;
      n_checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL halt_clear: got h%0b addr %h expected h0 0", bus.halted, bus.imem_addr); end
      step();
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL halt_resume: got %0b/%h expected 1/0", bus.inst_valid, bus.inst_pc); end
      mem[13] = saved;
   endtask
`endif

   task automatic test_random();
      fetch_entry_t mq[$];
      fetch_entry_t e;
      logic [31:0]  mpc = RESET_PC;
      logic [31:0]  w;
      bit           mhalt = 1'b0;
      bit           mhalted = 1'b0;
      bit           nh;
      logic [31:0]  saved;
      saved = mem[17];
      if (HALT_EN) mem[17] = HALT_WORD;
      for (int cyc = 0; cyc < 800; cyc++) begin
         reset              = (cyc == 0) || ($urandom_range(99) == 0);
         bus.inst_ready     = ($urandom_range(9) < 7);
         bus.redirect_valid = ($urandom_range(19) == 0);
         bus.redirect_pc    = 32'($urandom_range(4 * MEM_WORDS + 12));
         if (reset) begin
            mq.delete(); mpc = RESET_PC; mhalt = 1'b0; mhalted = 1'b0;
         end else if (bus.redirect_valid) begin
            mq.delete(); mpc = bus.redirect_pc & 32'hFFFF_FFFC; mhalt = 1'b0; mhalted = 1'b0;
         end else begin
            nh = mhalt && (mq.size() == 0);
            if (mq.size() != 0 && bus.inst_ready) void'(mq.pop_front());
            if (!mhalt && mq.size() < FIFO_DEPTH) begin
               w = mem_read(mpc);
               e.pc = mpc; e.word = w;
               mq.push_back(e);
               if (HALT_EN && w == HALT_WORD) mhalt = 1'b1;
               else mpc = (mpc == 32'(4 * (MEM_WORDS - 1))) ? 32'h0 : mpc + 32'd4;
            end
            mhalted = nh;
         end
         step();
         n_checks++; if (bus.inst_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d: got %0b expected %0b", cyc, bus.inst_valid, mq.size() != 0); end
         if (mq.size() != 0) begin
            n_checks++; if (bus.inst_pc !== mq[0].pc || bus.inst_word !== mq[0].word) begin n_fail++; $display("FAIL rnd_head cyc=%0d: got %h:%h expected %h:%h", cyc, bus.inst_pc, bus.inst_word, mq[0].pc, mq[0].word); end
         end
         n_checks++; if (bus.imem_addr !== mpc) begin n_fail++; $display("FAIL rnd_addr cyc=%0d: got %h expected %h", cyc, bus.imem_addr, mpc); end
         n_checks++; if (bus.halted !== mhalted) begin n_fail++; $display("FAIL rnd_halted cyc=%0d: got %0b expected %0b", cyc, bus.halted, mhalted); end
      end
      mem[17] = saved;
      reset = 1'b0; bus.redirect_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom();
         if (mem[i] == HALT_WORD) mem[i] = 32'h0000_0013;
      end
      test_reset();
      test_cold_start();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_reset_mid();
`ifdef HALT_DETECT_EN
      test_halt();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
